// File: rtl/record_field_arbiter.sv
// record_field_arbiter: round-robin arbiter that owns one 16-bit packed record
// (high = [15:8], low = [7:0]) and lets requesters write either byte or both.
// Optional lock timeout is enabled with `define RECORD_FIELD_ARB_LOCK_TIMEOUT_EN.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   req        per-requester write request (hold until granted)
//   lock       per-requester lock request, sampled in the grant cycle
//   fsel       per-requester field enables, [2i]=low byte, [2i+1]=high byte
//   wdata      per-requester record data, slice [16i+15:16i]
//   gnt        registered one-hot grant
//   owner      index of current grantee (valid when busy)
//   busy       any grant bit set
//   rec_q      shared record value
//   timeout_o  one-cycle pulse when a lock is forcibly released
module record_field_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [2*NREQ-1:0]       fsel,
    input  logic [16*NREQ-1:0]      wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic [15:0]             rec_q,
    output logic                    timeout_o
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
    localparam logic [IW-1:0] LAST   = IW'(NREQ - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("NREQ must be in 2..8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be >= 2");
    end

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic [15:0]     r_rec;

    logic [1:0]      w_fs_a [NREQ];
    logic [15:0]     w_wd_a [NREQ];
    logic [1:0]      w_fs;
    logic [15:0]     w_wd;
    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_win_oh;
    logic [IW-1:0]   w_win;
    logic [IW:0]     w_sum;
    logic            w_found;
    logic            w_busy;
    logic            w_own_req;
    logic            w_own_lock;
    logic            w_expire;
    logic            w_hold;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_fs_a[i] = fsel[2*i +: 2];
            w_wd_a[i] = wdata[16*i +: 16];
        end
    end

    assign w_fs       = w_fs_a[r_owner];
    assign w_wd       = w_wd_a[r_owner];
    assign w_busy     = |r_gnt;
    assign w_own_req  = w_busy & req[r_owner];
    assign w_own_lock = w_busy & lock[r_owner];

    // The current grantee is masked so it cannot win twice in a row.
    assign w_cand = req & ~r_gnt;

    // Search ptr, ptr+1, ... modulo NREQ; first candidate found wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            if (!w_found && w_cand[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IW-1:0];
            end
        end
    end

    assign w_win_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

`ifdef RECORD_FIELD_ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] r_cnt;
    logic          r_tout;

    assign w_expire = (r_state == S_LOCKED) && (r_cnt == CW'(TIMEOUT - 1));

    // Counts locked cycles from 0; cleared whenever the lock is not held over.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tout <= 1'b0;
        end else begin
            r_tout <= w_expire && w_own_lock;
            if (w_hold && r_state == S_LOCKED) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign timeout_o = r_tout;
`else
    assign w_expire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Lock is taken only when the grantee actually requests in its grant
    // cycle; once locked it persists until lock drops or the timer expires.
    assign w_hold = w_own_lock &&
                    ((r_state == S_GRANT && w_own_req) ||
                     (r_state == S_LOCKED && !w_expire));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_rec   <= 16'h0000;
        end else begin
            if (w_own_req) begin
                if (w_fs[0]) begin
                    r_rec[7:0] <= w_wd[7:0];
                end
                if (w_fs[1]) begin
                    r_rec[15:8] <= w_wd[15:8];
                end
            end

            if (w_hold) begin
                r_state <= S_LOCKED;
            end else if (w_found) begin
                r_state <= S_GRANT;
                r_gnt   <= w_win_oh;
                r_owner <= w_win;
                r_ptr   <= (w_win == LAST) ? '0 : w_win + 1'b1;
            end else begin
                r_state <= S_IDLE;
                r_gnt   <= '0;
            end
        end
    end

    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = w_busy;
    assign rec_q = r_rec;

endmodule

// File: tb/tb_record_field_arbiter.sv
// tb_record_field_arbiter: directed vector table plus hand sequences for
// lock hold, lock timeout and lone-requester behaviour.
module tb_record_field_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [7:0]  fsel;
    logic [63:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] rec_q;
    logic        timeout_o;

    always #5 clk = ~clk;

    record_field_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .fsel(fsel), .wdata(wdata), .gnt(gnt), .owner(owner),
        .busy(busy), .rec_q(rec_q), .timeout_o(timeout_o)
    );

`ifdef RECORD_FIELD_ARB_LOCK_TIMEOUT_EN
    logic [3:0]  gnt_t;
    logic [1:0]  owner_t;
    logic        busy_t;
    logic [15:0] rec_t;
    logic        tout_t;

    record_field_arbiter #(.NREQ(4), .TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .fsel(fsel), .wdata(wdata), .gnt(gnt_t), .owner(owner_t),
        .busy(busy_t), .rec_q(rec_t), .timeout_o(tout_t)
    );
`endif

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [7:0]  fsel;
        logic [63:0] wdata;
        logic [3:0]  egnt;
        logic [1:0]  eown;
        logic [15:0] erec;
        logic        etout;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input logic r, input logic [3:0] rq,
                                input logic [3:0] lk, input logic [7:0] fs,
                                input logic [63:0] wd, input logic [3:0] eg,
                                input logic [1:0] eo, input logic [15:0] er,
                                input logic et);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.fsel = fs; v.wdata = wd;
        v.egnt = eg; v.eown = eo; v.erec = er; v.etout = et;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] WA5 = 64'h0000_0000_0000_A55A;
    localparam logic [63:0] W2  = 64'hEE04_EE03_EE02_EE01;
    localparam logic [63:0] W3  = 64'h0000_0044_3300_0000;
    localparam logic [63:0] WA  = 64'h1234_0000_0000_00AB;
    localparam logic [63:0] WB  = 64'h5678_0000_0000_00AB;
    localparam logic [63:0] WC  = 64'h9ABC_0000_0000_00AB;
    localparam logic [63:0] W4  = 64'h0000_0000_1111_0000;
    localparam logic [63:0] W5  = 64'h0000_0000_2222_0000;
    localparam logic [63:0] W6  = 64'h0000_0000_FFFF_0000;

    initial begin
        rst = 1'b1; req = '0; lock = '0; fsel = '0; wdata = '0;

        // reset, single request, ptr moved to 1
        add(1, 4'b0000, 4'b0000, 8'h00, 64'h0, 4'b0000, 2'd0, 16'h0000, 0);
        add(0, 4'b0001, 4'b0000, 8'h03, WA5,  4'b0001, 2'd0, 16'h0000, 0);
        add(0, 4'b0001, 4'b0000, 8'h03, WA5,  4'b0000, 2'd0, 16'hA55A, 0);
        add(0, 4'b0011, 4'b0000, 8'h00, 64'h0, 4'b0010, 2'd1, 16'hA55A, 0);
        add(0, 4'b0011, 4'b0000, 8'h00, 64'h0, 4'b0001, 2'd0, 16'hA55A, 0);
        add(0, 4'b0000, 4'b0000, 8'h00, 64'h0, 4'b0000, 2'd0, 16'hA55A, 0);
        // round robin with wrap, low byte only
        add(1, 4'b0000, 4'b0000, 8'h00, 64'h0, 4'b0000, 2'd0, 16'h0000, 0);
        add(0, 4'b1111, 4'b0000, 8'h55, W2, 4'b0001, 2'd0, 16'h0000, 0);
        add(0, 4'b1111, 4'b0000, 8'h55, W2, 4'b0010, 2'd1, 16'h0001, 0);
        add(0, 4'b1111, 4'b0000, 8'h55, W2, 4'b0100, 2'd2, 16'h0002, 0);
        add(0, 4'b1111, 4'b0000, 8'h55, W2, 4'b1000, 2'd3, 16'h0003, 0);
        add(0, 4'b1111, 4'b0000, 8'h55, W2, 4'b0001, 2'd0, 16'h0004, 0);
        add(0, 4'b0000, 4'b0000, 8'h55, W2, 4'b0000, 2'd0, 16'h0004, 0);
        // field merge
        add(0, 4'b0010, 4'b0000, 8'h18, W3, 4'b0010, 2'd1, 16'h0004, 0);
        add(0, 4'b0010, 4'b0000, 8'h18, W3, 4'b0000, 2'd0, 16'h3304, 0);
        add(0, 4'b0100, 4'b0000, 8'h18, W3, 4'b0100, 2'd2, 16'h3304, 0);
        add(0, 4'b0100, 4'b0000, 8'h18, W3, 4'b0000, 2'd0, 16'h3344, 0);
        add(0, 4'b0000, 4'b0000, 8'h18, W3, 4'b0000, 2'd0, 16'h3344, 0);
        // lock by requester 3 with requester 0 waiting
        add(0, 4'b1001, 4'b1000, 8'hC1, WA, 4'b1000, 2'd3, 16'h3344, 0);
        add(0, 4'b1001, 4'b1000, 8'hC1, WA, 4'b1000, 2'd3, 16'h1234, 0);
        add(0, 4'b1001, 4'b1000, 8'hC1, WB, 4'b1000, 2'd3, 16'h5678, 0);
        add(0, 4'b1001, 4'b1000, 8'hC1, WB, 4'b1000, 2'd3, 16'h5678, 0);
        add(0, 4'b1001, 4'b1000, 8'hC1, WB, 4'b1000, 2'd3, 16'h5678, 0);
        add(0, 4'b1001, 4'b0000, 8'hC1, WC, 4'b0001, 2'd0, 16'h9ABC, 0);
        add(0, 4'b0001, 4'b0000, 8'hC1, WC, 4'b0000, 2'd0, 16'h9AAB, 0);
        add(0, 4'b0000, 4'b0000, 8'hC1, WC, 4'b0000, 2'd0, 16'h9AAB, 0);
        // reset in the second locked cycle
        add(0, 4'b0010, 4'b0010, 8'h0C, W4, 4'b0010, 2'd1, 16'h9AAB, 0);
        add(0, 4'b0010, 4'b0010, 8'h0C, W4, 4'b0010, 2'd1, 16'h1111, 0);
        add(0, 4'b0010, 4'b0010, 8'h0C, W5, 4'b0010, 2'd1, 16'h2222, 0);
        add(1, 4'b0010, 4'b0010, 8'h0C, W6, 4'b0000, 2'd0, 16'h0000, 0);
        add(0, 4'b0000, 4'b0000, 8'h00, 64'h0, 4'b0000, 2'd0, 16'h0000, 0);
        add(0, 4'b0011, 4'b0000, 8'h00, 64'h0, 4'b0001, 2'd0, 16'h0000, 0);
        add(0, 4'b0000, 4'b0000, 8'h00, 64'h0, 4'b0000, 2'd0, 16'h0000, 0);
        // lone requester granted every other cycle
        add(0, 4'b0001, 4'b0000, 8'h00, 64'h0, 4'b0001, 2'd0, 16'h0000, 0);
        add(0, 4'b0001, 4'b0000, 8'h00, 64'h0, 4'b0000, 2'd0, 16'h0000, 0);
        add(0, 4'b0001, 4'b0000, 8'h00, 64'h0, 4'b0001, 2'd0, 16'h0000, 0);
        add(0, 4'b0001, 4'b0000, 8'h00, 64'h0, 4'b0000, 2'd0, 16'h0000, 0);
        add(0, 4'b0000, 4'b0000, 8'h00, 64'h0, 4'b0000, 2'd0, 16'h0000, 0);

        for (int i = 0; i < vq.size(); i++) begin
            rst   = vq[i].rst;
            req   = vq[i].req;
            lock  = vq[i].lock;
            fsel  = vq[i].fsel;
            wdata = vq[i].wdata;
            step();
            chk("gnt", i, 16'(gnt), 16'(vq[i].egnt));
            chk("busy", i, 16'(busy), 16'(|vq[i].egnt));
            chk("rec_q", i, rec_q, vq[i].erec);
            chk("timeout_o", i, 16'(timeout_o), 16'(vq[i].etout));
            if (vq[i].egnt != 4'b0000 || vq[i].rst) begin
                chk("owner", i, 16'(owner), 16'(vq[i].eown));
            end
        end

        // requester 2 takes a lock and writes its cycle number each cycle
        rst = 1'b1; req = '0; lock = '0; fsel = '0; wdata = '0;
        step();
        rst  = 1'b0;
        req  = 4'b0100;
        lock = 4'b0100;
        fsel = 8'h30;

`ifdef RECORD_FIELD_ARB_LOCK_TIMEOUT_EN
        // TIMEOUT=4: released after 4 locked cycles, re-granted after one gap
        for (int k = 1; k <= 8; k++) begin
            logic [15:0] er;
            wdata = {16'h0, 16'(k), 32'h0};
            step();
            er = (k == 1) ? 16'h0 : (k == 7) ? 16'd6 : 16'(k);
            chk("to_gnt", 100 + k, 16'(gnt_t), (k == 6) ? 16'h0 : 16'h4);
            chk("to_pulse", 100 + k, 16'(tout_t), (k == 6) ? 16'h1 : 16'h0);
            chk("to_rec", 100 + k, rec_t, er);
        end
`else
        // no timeout: lock held well past TIMEOUT cycles
        for (int k = 1; k <= 20; k++) begin
            wdata = {16'h0, 16'(k), 32'h0};
            step();
            chk("hold_gnt", 100 + k, 16'(gnt), 16'h4);
            chk("hold_tout", 100 + k, 16'(timeout_o), 16'h0);
            chk("hold_rec", 100 + k, rec_q, (k == 1) ? 16'h0 : 16'(k));
        end
        lock  = 4'b0000;
        wdata = {16'h0, 16'h00AA, 32'h0};
        step();
        chk("release_gnt", 121, 16'(gnt), 16'h0);
        chk("release_rec", 121, rec_q, 16'h00AA);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
